pio_write_arbiter: RTL

- Avalon-MM master that shares one 32-bit-data PIO output slave (address 0 = output data register) among NUM_REQ requesters.
- Round-robin arbitration; one zero-wait-state write per grant, optional readback check, then a programmable hold-off so the driven port value stays stable for a minimum time.
- Sits between control logic (FSMs, button debouncers) and the PIO slave in the system interconnect.

---
 rtl/pio_write_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pio_write_arbiter.sv
// Round-robin Avalon-MM writer sharing one PIO data register among NUM_REQ requesters; req->strobe 1 cycle, ack 3 cycles (2 without
// PIO_ARB_READBACK_EN), then HOLD_CYCLES idle; requesters hold req level until ack, so no backpressure beyond waiting for a grant.
module pio_write_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int DATA_W      = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      busy,
   output logic                      err,
   input  logic                      err_clr,
   output logic [1:0]                avm_address,
   output logic                      avm_chipselect,
   output logic                      avm_write_n,
   output logic [31:0]               avm_writedata,
   input  logic [31:0]               avm_readdata
);

   localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DONE,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [IDX_W-1:0]  win_q, win_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0]        hold_q, hold_d;

   logic              grant_found;
   logic [IDX_W-1:0]  grant_idx;
   logic [DATA_W-1:0] grant_data;
   int                cand;

   // Scan starts just after the last winner, so the previous winner ends up lowest priority.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(last_q) + off) % NUM_REQ;
         if (!grant_found && req[IDX_W'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            grant_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      data_d  = data_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               win_d   = grant_idx;
               data_d  = grant_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
`ifdef PIO_ARB_READBACK_EN
            state_d = S_READ;
`else
            state_d = S_DONE;
`endif
         end
         S_READ: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            last_d = win_q;
            if (HOLD_CYCLES > 0) begin
               hold_d  = 8'(HOLD_CYCLES);
               state_d = S_HOLD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            // Leaving on a count of 1 gives exactly HOLD_CYCLES cycles here.
            if (hold_q <= 8'd1) begin
               hold_d  = '0;
               state_d = S_IDLE;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         last_q  <= IDX_W'(NUM_REQ - 1);
         win_q   <= '0;
         data_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         data_q  <= data_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         ack[i] = (state_q == S_DONE) && (win_q == IDX_W'(i));
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign avm_address    = 2'b00;
   assign avm_chipselect = (state_q == S_WRITE) || (state_q == S_READ);
   assign avm_write_n    = (state_q != S_WRITE);
   assign avm_writedata  = 32'(data_q);

`ifdef PIO_ARB_READBACK_EN
   logic err_q, err_d;
   logic rb_mismatch;
   logic unused_rd;

   // A mismatch in the same cycle as err_clr must leave the flag set.
   always_comb begin
      rb_mismatch = (state_q == S_READ) && (avm_readdata[DATA_W-1:0] != data_q);
      err_d       = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (rb_mismatch) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err       = err_q;
   assign unused_rd = &{1'b0, avm_readdata};
`else
   logic unused_rd;

   assign err       = 1'b0;
   assign unused_rd = &{1'b0, avm_readdata, err_clr};
`endif

endmodule
